// File: rtl/lin_pkg.sv
// Shared constants, FSM state type and helpers for the LIN bus fabric.
package lin_pkg;

  localparam int unsigned LIN_WORD_W = 10;
  localparam logic [LIN_WORD_W-1:0] LIN_BREAK     = 10'h000;
  localparam logic [LIN_WORD_W-1:0] LIN_RECESSIVE = 10'h3FF;
  localparam logic [7:0]            LIN_SYNC      = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CKSUM
  } lin_state_t;

  // Response length in data bytes, selected by identifier bits [5:4].
  function automatic logic [3:0] lin_data_len(input logic [1:0] id_hi);
    case (id_hi)
      2'b10:   return 4'd4;
      2'b11:   return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  // Returns {P1, P0} for a 6-bit identifier.
  function automatic logic [1:0] lin_pid_parity(input logic [5:0] id);
    return {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4]};
  endfunction

endpackage

// File: rtl/lin_bus_timer.sv
// Saturating up-counter with synchronous clear; at_limit is high while count == LIMIT.
module lin_bus_timer
  import lin_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LIMIT = 4000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/lin_bus_fabric.sv
// Word-level LIN bus: wired-AND merge of one master and NUM_SLAVES slaves plus frame tracking.
// Optional PID parity checking is enabled by defining LIN_PID_PARITY_CHECK_EN.
module lin_bus_fabric
  import lin_pkg::*;
#(
  parameter int unsigned NUM_SLAVES   = 2,
  parameter int unsigned IDLE_TIMEOUT = 4000,
  parameter int unsigned RESP_TIMEOUT = 200,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [LIN_WORD_W-1:0]            m_tx_word,
  input  logic                             m_tx_valid,
  input  logic [LIN_WORD_W*NUM_SLAVES-1:0] s_tx_word,
  input  logic [NUM_SLAVES-1:0]            s_tx_valid,
  output logic [LIN_WORD_W-1:0]            bus_word,
  output logic                             bus_valid,
  output logic                             header_rcvd,
  output logic [5:0]                       pid,
  output logic                             frame_done,
  output logic                             collision,
  output logic                             framing_err,
  output logic                             resp_timeout,
  output logic                             bus_inactive
);

  logic [LIN_WORD_W-1:0] and_w;
  logic [LIN_WORD_W-1:0] or_w;
  logic                  any_valid;

  // Drivers disagree exactly when the AND and OR of their words differ.
  always_comb begin
    and_w     = '1;
    or_w      = '0;
    any_valid = m_tx_valid;
    if (m_tx_valid) begin
      and_w = and_w & m_tx_word;
      or_w  = or_w | m_tx_word;
    end
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (s_tx_valid[k]) begin
        and_w     = and_w & s_tx_word[LIN_WORD_W*k +: LIN_WORD_W];
        or_w      = or_w | s_tx_word[LIN_WORD_W*k +: LIN_WORD_W];
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_word  <= LIN_RECESSIVE;
      bus_valid <= 1'b0;
      collision <= 1'b0;
    end else begin
      bus_valid <= any_valid;
      collision <= any_valid && (and_w != or_w);
      if (any_valid) begin
        bus_word <= and_w;
      end
    end
  end

  lin_state_t state;
  logic [3:0] len;
  logic [3:0] byte_cnt;
  logic       byte_ok;
  logic       pid_par_ok;
  logic       in_resp;
  logic       resp_due;

  assign byte_ok = ~bus_word[0] & bus_word[9];
  assign in_resp = (state == DATA) || (state == CKSUM);

`ifdef LIN_PID_PARITY_CHECK_EN
  assign pid_par_ok = (bus_word[8:7] == lin_pid_parity(bus_word[6:1]));
`else
  assign pid_par_ok = 1'b1;
`endif

  lin_bus_timer #(
    .CNT_W (CNT_W),
    .LIMIT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus_valid),
    .at_limit (bus_inactive)
  );

  // Limit is one short so the timeout registers on the edge where the gap reaches RESP_TIMEOUT.
  lin_bus_timer #(
    .CNT_W (CNT_W),
    .LIMIT (RESP_TIMEOUT - 1)
  ) u_resp_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus_valid | ~in_resp),
    .at_limit (resp_due)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pid          <= '0;
      len          <= 4'd2;
      byte_cnt     <= '0;
      header_rcvd  <= 1'b0;
      frame_done   <= 1'b0;
      framing_err  <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      header_rcvd  <= 1'b0;
      frame_done   <= 1'b0;
      framing_err  <= 1'b0;
      resp_timeout <= 1'b0;
      if (bus_valid) begin
        if (bus_word == LIN_BREAK) begin
          state <= SYNC;
        end else if (!byte_ok) begin
          framing_err <= 1'b1;
          state       <= IDLE;
        end else begin
          case (state)
            IDLE: ;
            SYNC: begin
              if (bus_word[8:1] == LIN_SYNC) begin
                state <= PID;
              end else begin
                framing_err <= 1'b1;
                state       <= IDLE;
              end
            end
            PID: begin
              if (pid_par_ok) begin
                pid         <= bus_word[6:1];
                len         <= lin_data_len(bus_word[6:5]);
                byte_cnt    <= '0;
                header_rcvd <= 1'b1;
                state       <= DATA;
              end else begin
                framing_err <= 1'b1;
                state       <= IDLE;
              end
            end
            DATA: begin
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt + 1'b1 == len) begin
                state <= CKSUM;
              end
            end
            CKSUM: begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end else if (in_resp && resp_due) begin
        resp_timeout <= 1'b1;
        state        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lin_bus_fabric.sv
// Self-checking bench for lin_bus_fabric: vector table, directed corner sequences, random frames vs. model.
module tb_lin_bus_fabric;

  localparam int NS     = 2;
  localparam int IDLE_T = 4000;
  localparam int RESP_T = 200;

  logic        clk;
  logic        reset;
  logic [9:0]  m_tx_word;
  logic        m_tx_valid;
  logic [19:0] s_tx_word;
  logic [1:0]  s_tx_valid;
  logic [9:0]  bus_word;
  logic        bus_valid;
  logic        header_rcvd;
  logic [5:0]  pid;
  logic        frame_done;
  logic        collision;
  logic        framing_err;
  logic        resp_timeout;
  logic        bus_inactive;

  lin_bus_fabric #(
    .NUM_SLAVES   (NS),
    .IDLE_TIMEOUT (IDLE_T),
    .RESP_TIMEOUT (RESP_T),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_tx_word    (m_tx_word),
    .m_tx_valid   (m_tx_valid),
    .s_tx_word    (s_tx_word),
    .s_tx_valid   (s_tx_valid),
    .bus_word     (bus_word),
    .bus_valid    (bus_valid),
    .header_rcvd  (header_rcvd),
    .pid          (pid),
    .frame_done   (frame_done),
    .collision    (collision),
    .framing_err  (framing_err),
    .resp_timeout (resp_timeout),
    .bus_inactive (bus_inactive)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int n_hdr = 0, n_done = 0, n_ferr = 0, n_tmo = 0;

  // Reference model: expected outputs after the coming edge.
  logic [9:0] e_word = 10'h3FF;
  logic       e_valid = 1'b0, e_coll = 1'b0, e_hdr = 1'b0, e_done = 1'b0, e_ferr = 1'b0, e_tmo = 1'b0;
  logic [5:0] e_pid = '0;
  int phase = 0;          // 0 no frame, 1 want sync, 2 want pid, 3 response in progress
  int remaining = 0;      // response bytes still expected, checksum included
  int cyc = 0, quiet_since = 0, last_valid_cyc = -1000000;

  function automatic logic [9:0] fw(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic bit par_ok(input logic [7:0] b);
    logic [1:0] p;
    bit strict;
    p = {~(b[1] ^ b[3] ^ b[4] ^ b[5]), b[0] ^ b[1] ^ b[2] ^ b[4]};
`ifdef LIN_PID_PARITY_CHECK_EN
    strict = 1'b1;
`else
    strict = 1'b0;
`endif
    return !strict || (p == b[7:6]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic mv, input logic [9:0] mw, input logic [1:0] sv, input logic [19:0] sw);
    logic [9:0] ow, aw, first, w;
    logic       ov, any, diff;
    logic [7:0] b;
    m_tx_valid = mv;
    m_tx_word  = mw;
    s_tx_valid = sv;
    s_tx_word  = sw;
    if (reset) begin
      e_word = 10'h3FF; e_valid = 0; e_coll = 0;
      e_hdr = 0; e_done = 0; e_ferr = 0; e_tmo = 0; e_pid = '0;
      phase = 0; remaining = 0; cyc = 0; quiet_since = 0; last_valid_cyc = -1000000;
    end else begin
      ow = e_word; ov = e_valid;
      e_hdr = 0; e_done = 0; e_ferr = 0; e_tmo = 0;
      if (ov) begin
        last_valid_cyc = cyc;
        quiet_since    = cyc + 1;
        if (ow == 10'h000) begin
          phase = 1;
        end else if (ow[0] != 1'b0 || ow[9] != 1'b1) begin
          e_ferr = 1; phase = 0;
        end else begin
          b = ow[8:1];
          case (phase)
            1: if (b == 8'h55) phase = 2; else begin e_ferr = 1; phase = 0; end
            2: if (par_ok(b)) begin
                 e_pid = b[5:0];
                 remaining = (b[5] ? (b[4] ? 8 : 4) : 2) + 1;
                 e_hdr = 1; phase = 3;
               end else begin
                 e_ferr = 1; phase = 0;
               end
            3: begin
                 remaining--;
                 if (remaining == 0) begin e_done = 1; phase = 0; end
               end
            default: ;
          endcase
        end
      end else if (phase == 3 && cyc - last_valid_cyc == RESP_T) begin
        e_tmo = 1; phase = 0;
      end
      any = 0; aw = '1; diff = 0; first = '0;
      if (mv) begin any = 1; first = mw; aw = aw & mw; end
      for (int k = 0; k < NS; k++) begin
        if (sv[k]) begin
          w = sw[10*k +: 10];
          if (!any) first = w;
          else if (w != first) diff = 1;
          any = 1;
          aw = aw & w;
        end
      end
      if (any) begin e_word = aw; e_valid = 1; e_coll = diff; end
      else begin e_valid = 0; e_coll = 0; end
      cyc++;
    end
    @(posedge clk);
    #1;
    n_hdr  += int'(header_rcvd);
    n_done += int'(frame_done);
    n_ferr += int'(framing_err);
    n_tmo  += int'(resp_timeout);
    chk("cycle{word,valid,coll,hdr,done,ferr,tmo,inact,pid}",
        32'({bus_word, bus_valid, collision, header_rcvd, frame_done, framing_err, resp_timeout, bus_inactive, pid}),
        32'({e_word, e_valid, e_coll, e_hdr, e_done, e_ferr, e_tmo, ((cyc - quiet_since) >= IDLE_T), e_pid}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'b00, '0);
  endtask

  task automatic send_m(input logic [9:0] w);
    step(1'b1, w, 2'b00, '0);
  endtask

  task automatic send_s(input int k, input logic [9:0] w);
    logic [19:0] sw;
    logic [1:0]  sv;
    sw = '0; sv = '0;
    sw[10*k +: 10] = w;
    sv[k] = 1'b1;
    step(1'b0, '0, sv, sw);
  endtask

  task automatic hdr(input logic [7:0] pid_byte);
    send_m(10'h000);
    send_m(fw(8'h55));
    send_m(fw(pid_byte));
  endtask

  typedef struct {
    logic        mv;
    logic [9:0]  mw;
    logic [1:0]  sv;
    logic [19:0] sw;
    logic [9:0]  e_word;
    logic        e_valid, e_coll, e_hdr, e_done, e_ferr;
    logic [5:0]  e_pid;
  } vec_t;

  vec_t tbl[12];
  int b_hdr, b_done, b_ferr, b_tmo;
  logic [9:0] rw;

  initial begin
    // PID byte 0x50 is id 0x10 with correct parity, so it is accepted in both builds.
    tbl[0]  = '{1, 10'h000,      2'b00, 20'h0,                      10'h000,      1, 0, 0, 0, 0, 6'h00};
    tbl[1]  = '{1, fw(8'h55),    2'b00, 20'h0,                      fw(8'h55),    1, 0, 0, 0, 0, 6'h00};
    tbl[2]  = '{1, fw(8'h50),    2'b00, 20'h0,                      fw(8'h50),    1, 0, 0, 0, 0, 6'h00};
    tbl[3]  = '{0, 10'h000,      2'b01, {10'h0, fw(8'h11)},         fw(8'h11),    1, 0, 1, 0, 0, 6'h10};
    tbl[4]  = '{0, 10'h000,      2'b01, {10'h0, fw(8'h22)},         fw(8'h22),    1, 0, 0, 0, 0, 6'h10};
    tbl[5]  = '{0, 10'h000,      2'b01, {10'h0, fw(8'hCC)},         fw(8'hCC),    1, 0, 0, 0, 0, 6'h10};
    tbl[6]  = '{0, 10'h000,      2'b00, 20'h0,                      fw(8'hCC),    0, 0, 0, 1, 0, 6'h10};
    tbl[7]  = '{1, fw(8'hFF),    2'b10, {fw(8'h0F), 10'h0},         fw(8'h0F),    1, 1, 0, 0, 0, 6'h10};
    tbl[8]  = '{1, fw(8'h55),    2'b01, {10'h0, fw(8'h55)},         fw(8'h55),    1, 0, 0, 0, 0, 6'h10};
    tbl[9]  = '{1, fw(8'hFF),    2'b11, {fw(8'hFF), fw(8'hFF)},     fw(8'hFF),    1, 0, 0, 0, 0, 6'h10};
    tbl[10] = '{0, 10'h000,      2'b11, {fw(8'hFE), fw(8'hFF)},     fw(8'hFE),    1, 1, 0, 0, 0, 6'h10};
    tbl[11] = '{0, 10'h000,      2'b00, 20'h0,                      fw(8'hFE),    0, 0, 0, 0, 0, 6'h10};

    reset = 1'b1;
    m_tx_valid = 0; m_tx_word = '0; s_tx_valid = '0; s_tx_word = '0;
    idle(3);
    reset = 1'b0;
    chk("reset_bus_word", 32'(bus_word), 32'(10'h3FF));
    chk("reset_pid", 32'(pid), 32'(0));
    chk("reset_flags", 32'({bus_valid, header_rcvd, frame_done, collision, framing_err, resp_timeout, bus_inactive}), 32'(0));

    // Inactivity: counting from the first cycle after reset.
    for (int k = 1; k <= IDLE_T; k++) begin
      idle(1);
      if (k == IDLE_T - 1) chk("inactive_before_limit", 32'(bus_inactive), 32'(0));
      if (k == IDLE_T)     chk("inactive_at_limit", 32'(bus_inactive), 32'(1));
    end
    send_m(10'h000);
    chk("inactive_during_valid", 32'({bus_valid, bus_inactive}), 32'(2'b11));
    idle(1);
    chk("inactive_cleared", 32'(bus_inactive), 32'(0));

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].mv, tbl[i].mw, tbl[i].sv, tbl[i].sw);
      chk($sformatf("vec%0d", i),
          32'({bus_word, bus_valid, collision, header_rcvd, frame_done, framing_err, pid}),
          32'({tbl[i].e_word, tbl[i].e_valid, tbl[i].e_coll, tbl[i].e_hdr, tbl[i].e_done, tbl[i].e_ferr, tbl[i].e_pid}));
    end

    // Response timeout: id 0x30 (len 8), slave stops after 3 bytes.
    b_hdr = n_hdr; b_done = n_done; b_ferr = n_ferr; b_tmo = n_tmo;
    hdr(8'hF0);
    send_s(0, fw(8'h01)); send_s(0, fw(8'h02)); send_s(0, fw(8'h03));
    idle(RESP_T);
    chk("tmo_not_early", 32'(n_tmo - b_tmo), 32'(0));
    idle(1);
    chk("tmo_exact", 32'(resp_timeout), 32'(1));
    chk("tmo_pid", 32'(pid), 32'(6'h30));
    for (int i = 0; i < 6; i++) send_s(1, fw(8'h40));
    idle(3);
    chk("tmo_back_to_idle", 32'({n_done - b_done, n_ferr - b_ferr, n_hdr - b_hdr}), 32'({32'd0, 32'd0, 32'd1}));

    // A word landing on the deadline cycle cancels the timeout.
    b_tmo = n_tmo;
    hdr(8'hF0);
    send_s(0, fw(8'h01));
    idle(RESP_T - 1);
    send_s(1, fw(8'h02));
    idle(3);
    chk("tmo_cancelled", 32'(n_tmo - b_tmo), 32'(0));
    send_m(10'h000);
    idle(2);

    // Framing errors: bad sync, then missing stop bit in the response.
    b_ferr = n_ferr; b_done = n_done;
    send_m(10'h000);
    send_m(fw(8'h54));
    idle(2);
    chk("ferr_bad_sync", 32'(n_ferr - b_ferr), 32'(1));
    hdr(8'h50);
    send_s(0, fw(8'h01));
    send_s(0, 10'h022);
    idle(2);
    chk("ferr_bad_stop", 32'(n_ferr - b_ferr), 32'(2));
    send_s(0, fw(8'h02));
    send_s(0, fw(8'h03));
    idle(2);
    chk("ferr_to_idle", 32'(n_done - b_done), 32'(0));

    // Break mid-response resynchronises without an error.
    b_ferr = n_ferr; b_done = n_done; b_hdr = n_hdr;
    hdr(8'h50);
    send_s(0, fw(8'h01));
    send_m(10'h000);
    send_m(fw(8'h55));
    send_m(fw(8'h50));
    send_s(0, fw(8'h01)); send_s(0, fw(8'h02)); send_s(0, fw(8'h03));
    idle(2);
    chk("break_resync", 32'({n_ferr - b_ferr, n_hdr - b_hdr, n_done - b_done}), 32'({32'd0, 32'd2, 32'd1}));

    // PID parity: 0x00 is wrong for id 0, 0x80 is right.
    b_ferr = n_ferr; b_hdr = n_hdr;
    hdr(8'h00);
    idle(2);
`ifdef LIN_PID_PARITY_CHECK_EN
    chk("parity_bad", 32'({n_ferr - b_ferr, n_hdr - b_hdr}), 32'({32'd1, 32'd0}));
    chk("parity_bad_pid", 32'(pid), 32'(6'h10));
`else
    chk("parity_ignored", 32'({n_ferr - b_ferr, n_hdr - b_hdr}), 32'({32'd0, 32'd1}));
    chk("parity_ignored_pid", 32'(pid), 32'(6'h00));
`endif
    b_hdr = n_hdr;
    send_m(10'h000); idle(1);
    hdr(8'h81);
    hdr(8'h80);
    idle(2);
    chk("parity_good", 32'({n_hdr - b_hdr, 26'd0, pid}), 32'({32'd1, 26'd0, 6'h00}));

    // Random frames against the model.
    for (int f = 0; f < 40; f++) begin
      int nb;
      send_m(10'h000);
      if ($urandom_range(0, 9) == 0) send_m(fw(rb())); else send_m(fw(8'h55));
      send_m(fw(rb()));
      nb = int'($urandom_range(0, 10));
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(RESP_T - 3, RESP_T + 3)));
        else idle(int'($urandom_range(0, 3)));
        case ($urandom_range(0, 19))
          0: send_s(0, 10'($urandom_range(0, 1023)));
          1: step(1'b0, '0, 2'b11, {fw(rb()), fw(rb())});
          2: begin rw = fw(rb()); step(1'b1, rw, 2'b11, {rw, rw}); end
          3: send_m(10'h000);
          default: send_s(int'($urandom_range(0, 1)), fw(rb()));
        endcase
      end
      idle(int'($urandom_range(0, 5)));
    end

    // Reset mid-frame discards the partial frame.
    b_done = n_done; b_ferr = n_ferr; b_tmo = n_tmo;
    hdr(8'h50);
    send_s(0, fw(8'h01));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midreset_state", 32'({bus_word, bus_valid, pid}), 32'({10'h3FF, 1'b0, 6'h00}));
    send_s(0, fw(8'h02));
    send_s(0, fw(8'h03));
    idle(3);
    chk("midreset_no_pulses", 32'({n_done - b_done, n_ferr - b_ferr, n_tmo - b_tmo}), 32'({32'd0, 32'd0, 32'd0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
